// File: rtl/digit_plane_buffer.sv
// digit_plane_buffer
// Collects N coefficients of four signed-digit words each, then streams the
// polynomial back out plane by plane: all first digits, then all second,
// third and fourth digits. One buffer; fill and drain never overlap.
// The read port loads the output register directly, so a beat is presented
// one cycle after its read is issued. A read is issued only when the output
// register is empty or is being emptied in the same cycle, which gives a full
// rate stream and exact k-cycle stalls without extra skid storage.

module digit_plane_buffer #(
    parameter int DATA_WIDTH = 28,
    parameter int N          = 512,
    parameter int IDX_W      = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_digit0,
    input  logic [DATA_WIDTH-1:0] in_digit1,
    input  logic [DATA_WIDTH-1:0] in_digit2,
    input  logic [DATA_WIDTH-1:0] in_digit3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_plane,
    output logic [IDX_W-1:0]      out_index,
    output logic                  out_last
);

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

    // One bank per digit plane
    logic [DATA_WIDTH-1:0] bank0_r [N];
    logic [DATA_WIDTH-1:0] bank1_r [N];
    logic [DATA_WIDTH-1:0] bank2_r [N];
    logic [DATA_WIDTH-1:0] bank3_r [N];

    state_t                state_r;
    logic                  in_ready_r;
    logic [IDX_W-1:0]      wr_idx_r;
    logic [1:0]            rd_plane_r;
    logic [IDX_W-1:0]      rd_idx_r;
    logic                  rd_done_r;

    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [1:0]            out_plane_r;
    logic [IDX_W-1:0]      out_index_r;
    logic                  out_last_r;

    logic                  accept_s;
    logic                  pop_s;
    logic                  issue_s;
    logic                  last_issue_s;
    logic                  finish_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    assign accept_s     = in_valid && in_ready_r;
    assign pop_s        = out_valid_r && out_ready;
    assign issue_s      = (state_r == ST_DRAIN) && !rd_done_r && (!out_valid_r || out_ready);
    assign last_issue_s = (rd_plane_r == 2'd3) && (rd_idx_r == IDX_MAX);
    assign finish_s     = pop_s && out_last_r;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_plane = out_plane_r;
    assign out_index = out_index_r;
    assign out_last  = out_last_r;

    // Write all four planes of the accepted coefficient in parallel
    always_ff @(posedge clk) begin
        if (accept_s) begin
            bank0_r[wr_idx_r] <= in_digit0;
            bank1_r[wr_idx_r] <= in_digit1;
            bank2_r[wr_idx_r] <= in_digit2;
            bank3_r[wr_idx_r] <= in_digit3;
        end
    end

    // Select the bank addressed by the current read plane
    always_comb begin
        rd_word_s = {DATA_WIDTH{1'b0}};
        case (rd_plane_r)
            2'd0:    rd_word_s = bank0_r[rd_idx_r];
            2'd1:    rd_word_s = bank1_r[rd_idx_r];
            2'd2:    rd_word_s = bank2_r[rd_idx_r];
            2'd3:    rd_word_s = bank3_r[rd_idx_r];
            default: rd_word_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Fill/drain sequencing: write index, read address walk and in_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_FILL;
            in_ready_r <= 1'b1;
            wr_idx_r   <= IDX_ZERO;
            rd_plane_r <= 2'd0;
            rd_idx_r   <= IDX_ZERO;
            rd_done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (accept_s) begin
                        if (wr_idx_r == IDX_MAX) begin
                            wr_idx_r   <= IDX_ZERO;
                            state_r    <= ST_DRAIN;
                            in_ready_r <= 1'b0;
                        end else begin
                            wr_idx_r <= wr_idx_r + IDX_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (finish_s) begin
                        state_r    <= ST_FILL;
                        in_ready_r <= 1'b1;
                        rd_plane_r <= 2'd0;
                        rd_idx_r   <= IDX_ZERO;
                        rd_done_r  <= 1'b0;
                    end else if (issue_s) begin
                        // Index is the inner loop, plane the outer loop
                        if (rd_idx_r == IDX_MAX) begin
                            rd_idx_r   <= IDX_ZERO;
                            rd_plane_r <= rd_plane_r + 2'd1;
                        end else begin
                            rd_idx_r <= rd_idx_r + IDX_ONE;
                        end
                        if (last_issue_s) begin
                            rd_done_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r    <= ST_FILL;
                    in_ready_r <= 1'b1;
                    wr_idx_r   <= IDX_ZERO;
                    rd_plane_r <= 2'd0;
                    rd_idx_r   <= IDX_ZERO;
                    rd_done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Output register: loaded by each read, held stable while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_plane_r <= 2'd0;
            out_index_r <= IDX_ZERO;
            out_last_r  <= 1'b0;
        end else if (issue_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= rd_word_s;
            out_plane_r <= rd_plane_r;
            out_index_r <= rd_idx_r;
            out_last_r  <= last_issue_s;
        end else if (pop_s) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end
    end

endmodule

// File: doc/digit_plane_buffer.md
# digit_plane_buffer

Coefficient-to-plane reorder buffer downstream of the signed-digit decomposer. Each input beat carries the four decomposed digits of one coefficient; digits are already reduced mod Q, with negative digits in the form Q−128+d. After N coefficients are collected, the block streams the polynomial out one digit plane at a time: all N first digits, then all N second, third and fourth digits. This is the order the per-digit NTT / external-product stage consumes. Single buffer, no fill/drain overlap.

## Interface
- DATA_WIDTH, 28: width of one digit word (mod-Q residue).
- N, 512: coefficients per polynomial; power of two, ≥ 4.
- IDX_W, $clog2(N): index width.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts input (high only in FILL).
- in_digit0..in_digit3  in  DATA_WIDTH each  first..fourth decomposed digit of current coefficient.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts output.
- out_data  out  DATA_WIDTH  digit word.
- out_plane  out  2  digit plane of out_data (0..3).
- out_index  out  IDX_W  coefficient index of out_data.
- out_last  out  1  high on plane-3, index N−1 beat.

## Operation
- Storage: four banks, each N×DATA_WIDTH. Bank p holds plane p. Synchronous-read RAM inferred. One write port (all four banks written in parallel). One read port (bank-muxed).
- States: FILL, DRAIN. Reset state FILL.
- FILL:
  - in_ready = 1.
  - On in_valid&&in_ready: write in_digitp to bank p at wr_idx, then wr_idx++.
  - On the accept with wr_idx = N−1: wr_idx wraps to 0 and the state goes to DRAIN.
- DRAIN:
  - in_ready = 0.
  - The read address is generated as (rd_plane, rd_idx), starting at (0,0). Index is the inner loop, plane the outer loop.
  - A beat is transferred on out_valid&&out_ready.
  - After the (3, N−1) beat transfers: counters clear and the state goes to FILL.
- Handshake rules:
  - out_valid, once high, holds with out_data/out_plane/out_index/out_last stable until out_ready.
  - in_valid while in_ready = 0 is ignored; no write occurs.
- Backpressure: a 2-entry output skid (or equivalent) absorbs read latency. Full rate is required: one beat per cycle while out_ready stays high.
- Data passes unmodified. No arithmetic on digit words. Counters are modulo-N / modulo-4, with wrap as above.
- Reset mid-operation (rst_n low at any time):
  - State goes to FILL; wr_idx, rd_plane, rd_idx go to 0.
  - Skid entries are invalidated.
  - Partial buffer contents are discarded (RAM not cleared; the data is simply never read).

## Timing
- Reset values: out_valid=0, out_data=0, out_plane=0, out_index=0, out_last=0. in_ready=1 (FILL), including while rst_n is low.
- Fill: N accepted beats minimum (N cycles with in_valid held high).
- Let cycle c be the Nth accept:
  - in_ready = 0 from c+1.
  - First read issues at c+1.
  - out_valid = 1 at c+2, carrying (plane 0, index 0).
- Drain with out_ready held high: beats at c+2 … c+2+4N−1, consecutive, no bubbles.
- Let cycle d be the one in which out_last transfers:
  - out_valid = 0 at d+1 (unless a new fill is already impossible, which it is).
  - in_ready = 1 at d+1.
- Out_ready low for k cycles stalls the stream by exactly k cycles. No beat is dropped or duplicated.
- Latency from first input accept to first output: N+1 cycles at full input rate.

## Test plan
- Reset/idle, N=8 bench: hold rst_n low 3 cycles, then release.
  - During and after reset: out_valid=0, in_ready=1.
  - in_valid=0 for 20 cycles → out_valid stays 0.
- Full-rate fill/drain, N=8:
  - Drive in_digitp = 100·p + i for i=0..7 back-to-back, out_ready=1.
  - out_valid first at 2 cycles after 8th accept.
  - 32 beats in order 0,1,…,7,100,…,107,200,…,307.
  - out_plane/out_index match; out_last only on value 307.
  - in_ready=1 the cycle after.
- Backpressure:
  - Same fill; toggle out_ready pseudo-randomly (≈40% high).
  - Identical 32-value sequence; outputs stable whenever out_valid&&!out_ready.
- Input gaps and ignored input:
  - Insert random in_valid gaps during fill → same output order.
  - During drain, drive in_valid=1 with digits 0xFFFFFFF every cycle → no effect on the current or next polynomial's data.
- Reset mid-operation:
  - Assert rst_n after 5 input beats, and separately after 10 output beats.
  - out_valid=0 immediately (asynchronous); in_ready=1.
  - A following full polynomial drains correctly from (0,0) with no stale beats.
- Back-to-back polynomials: two polynomials, values 1000+100·p+i and 2000+100·p+i → two complete 32-beat streams in order, no mixing.
